// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, writeback, issue and status bundle of the ALU reservation station
// master drives dispatch/wakeup/flush/issue_ready; slave (the station) drives issue and status.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif
interface rs_alu_if #(
  parameter int ENTRY_SEL = 3,
  parameter int OP_W = 4
);
  logic                 flush_i;
  logic                 dp_valid_i;
  logic [`DATA_LEN-1:0] dp_src1_i;
  logic                 dp_rdy1_i;
  logic [`DATA_LEN-1:0] dp_src2_i;
  logic                 dp_rdy2_i;
  logic [`RRF_SEL-1:0]  dp_rrftag_i;
  logic                 dp_dstval_i;
  logic [OP_W-1:0]      dp_op_i;
  logic                 wb0_valid_i;
  logic [`RRF_SEL-1:0]  wb0_rrftag_i;
  logic [`DATA_LEN-1:0] wb0_data_i;
  logic                 wb1_valid_i;
  logic [`RRF_SEL-1:0]  wb1_rrftag_i;
  logic [`DATA_LEN-1:0] wb1_data_i;
  logic                 issue_ready_i;
  logic                 issue_valid_o;
  logic [`DATA_LEN-1:0] issue_src1_o;
  logic [`DATA_LEN-1:0] issue_src2_o;
  logic [`RRF_SEL-1:0]  issue_rrftag_o;
  logic                 issue_dstval_o;
  logic [OP_W-1:0]      issue_op_o;
  logic                 full_o;
  logic [ENTRY_SEL:0]   count_o;
  modport master (
    output flush_i, dp_valid_i, dp_src1_i, dp_rdy1_i, dp_src2_i, dp_rdy2_i, dp_rrftag_i,
           dp_dstval_i, dp_op_i, wb0_valid_i, wb0_rrftag_i, wb0_data_i, wb1_valid_i,
           wb1_rrftag_i, wb1_data_i, issue_ready_i,
    input  issue_valid_o, issue_src1_o, issue_src2_o, issue_rrftag_o, issue_dstval_o,
           issue_op_o, full_o, count_o
  );
  modport slave (
    input  flush_i, dp_valid_i, dp_src1_i, dp_rdy1_i, dp_src2_i, dp_rdy2_i, dp_rrftag_i,
           dp_dstval_i, dp_op_i, wb0_valid_i, wb0_rrftag_i, wb0_data_i, wb1_valid_i,
           wb1_rrftag_i, wb1_data_i, issue_ready_i,
    output issue_valid_o, issue_src1_o, issue_src2_o, issue_rrftag_o, issue_dstval_o,
           issue_op_o, full_o, count_o
  );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: out-of-order ALU reservation station with dual-port wakeup and lowest-index issue
// Ports: clk_i clock, reset_i sync active-high reset, bus (rs_alu_if.slave) carrying
// flush, dispatch, two writeback broadcasts, issue valid/ready handshake, full and count.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif
module rs_alu #(
  parameter int ENTRY_NUM = 8,
  parameter int ENTRY_SEL = 3,
  parameter int OP_W = 4
) (
  input logic     clk_i,
  input logic     reset_i,
  rs_alu_if.slave bus
);
  localparam int DL = `DATA_LEN;
  localparam int RS = `RRF_SEL;
  logic [ENTRY_NUM-1:0] r_busy, r_rdy1, r_rdy2, r_dst;
  logic [DL-1:0]        r_src1 [ENTRY_NUM];
  logic [DL-1:0]        r_src2 [ENTRY_NUM];
  logic [RS-1:0]        r_tag [ENTRY_NUM];
  logic [OP_W-1:0]      r_op [ENTRY_NUM];
  logic [ENTRY_SEL:0]   r_count;
  logic [ENTRY_NUM-1:0] w_ready, w_issue_oh, w_alloc_oh;
  logic [ENTRY_SEL-1:0] w_sel, w_free;
  logic                 w_any, w_issue, w_alloc, w_full;
  logic                 w_wb0_v, w_wb1_v;
  logic [RS-1:0]        w_wb0_t, w_wb1_t;
  logic [DL-1:0]        w_wb0_d, w_wb1_d;
  assign w_wb0_v = bus.wb0_valid_i;
  assign w_wb0_t = bus.wb0_rrftag_i;
  assign w_wb0_d = bus.wb0_data_i;
  assign w_wb1_v = bus.wb1_valid_i;
  assign w_wb1_t = bus.wb1_rrftag_i;
  assign w_wb1_d = bus.wb1_data_i;
  // Returns {ready, value} after snooping both broadcast ports; port 0 has priority.
  function automatic logic [DL:0] wake(input logic rdy, input logic [DL-1:0] src);
    return rdy ? {1'b1, src} :
           (w_wb0_v && src[RS-1:0] == w_wb0_t) ? {1'b1, w_wb0_d} :
           (w_wb1_v && src[RS-1:0] == w_wb1_t) ? {1'b1, w_wb1_d} : {1'b0, src};
  endfunction
  assign w_ready = r_busy & r_rdy1 & r_rdy2;
  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    w_free = '0;
    for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
      if (w_ready[k]) begin
        w_sel = ENTRY_SEL'(k);
        w_any = 1'b1;
      end
      if (!r_busy[k]) w_free = ENTRY_SEL'(k);
    end
  end
  assign w_full = r_count == (ENTRY_SEL + 1)'(ENTRY_NUM);
  assign w_issue = w_any & bus.issue_ready_i;
  assign w_alloc = bus.dp_valid_i & ~w_full & ~bus.flush_i;
  assign w_issue_oh = ENTRY_NUM'(w_issue) << w_sel;
  assign w_alloc_oh = ENTRY_NUM'(w_alloc) << w_free;
  always_ff @(posedge clk_i) begin
    if (reset_i || bus.flush_i) begin
      r_busy <= '0;
      r_count <= '0;
    end else begin
      r_busy <= (r_busy & ~w_issue_oh) | w_alloc_oh;
      r_count <= r_count + (ENTRY_SEL + 1)'(w_alloc) - (ENTRY_SEL + 1)'(w_issue);
    end
  end
  // Payload is gated by busy, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < ENTRY_NUM; k++) begin
      if (w_alloc_oh[k]) begin
        {r_rdy1[k], r_src1[k]} <= wake(bus.dp_rdy1_i, bus.dp_src1_i);
        {r_rdy2[k], r_src2[k]} <= wake(bus.dp_rdy2_i, bus.dp_src2_i);
        r_tag[k] <= bus.dp_rrftag_i;
        r_dst[k] <= bus.dp_dstval_i;
        r_op[k] <= bus.dp_op_i;
      end else begin
        {r_rdy1[k], r_src1[k]} <= wake(r_rdy1[k], r_src1[k]);
        {r_rdy2[k], r_src2[k]} <= wake(r_rdy2[k], r_src2[k]);
      end
    end
  end
  assign bus.issue_valid_o = w_any;
  assign bus.issue_src1_o = w_any ? r_src1[w_sel] : '0;
  assign bus.issue_src2_o = w_any ? r_src2[w_sel] : '0;
  assign bus.issue_rrftag_o = w_any ? r_tag[w_sel] : '0;
  assign bus.issue_dstval_o = w_any & r_dst[w_sel];
  assign bus.issue_op_o = w_any ? r_op[w_sel] : '0;
  assign bus.full_o = w_full;
  assign bus.count_o = r_count;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed table, hand sequences and randomized model check of rs_alu
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif
module tb_rs_alu;
  localparam int DL = `DATA_LEN;
  localparam int RS = `RRF_SEL;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rs_alu_if #(.ENTRY_SEL(3), .OP_W(4)) bus ();
  rs_alu #(.ENTRY_NUM(N), .ENTRY_SEL(3), .OP_W(4)) dut (.clk_i(clk), .reset_i(rst), .bus(bus.slave));
  typedef struct {
    logic dv; logic [DL-1:0] s1; logic r1; logic [DL-1:0] s2; logic r2;
    logic [RS-1:0] tag; logic dst; logic [3:0] op;
    logic w0v; logic [RS-1:0] w0t; logic [DL-1:0] w0d;
    logic w1v; logic [RS-1:0] w1t; logic [DL-1:0] w1d;
    logic rdy; logic fl;
  } in_t;
  typedef struct {
    logic v; logic [DL-1:0] s1; logic [DL-1:0] s2; logic [RS-1:0] tag;
    logic dst; logic [3:0] op; logic [3:0] cnt; logic full;
  } exp_t;
  typedef struct {in_t vi; exp_t ve;} row_t;
  int n_pass = 0;
  int n_total = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask
  function automatic in_t idle(input logic rdy);
    in_t v;
    v = '{default: '0};
    v.rdy = rdy;
    return v;
  endfunction
  function automatic in_t disp(input logic [DL-1:0] s1, input logic r1, input logic [DL-1:0] s2,
                               input logic r2, input int tag, input int op, input logic rdy);
    in_t v;
    v = idle(rdy);
    v.dv = 1'b1; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2;
    v.tag = RS'(tag); v.op = 4'(op); v.dst = 1'b1;
    return v;
  endfunction
  function automatic in_t wb(input in_t v, input int p, input int t, input logic [DL-1:0] d);
    if (p == 0) begin v.w0v = 1'b1; v.w0t = RS'(t); v.w0d = d; end
    else begin v.w1v = 1'b1; v.w1t = RS'(t); v.w1d = d; end
    return v;
  endfunction
  function automatic exp_t ex(input logic v, input logic [DL-1:0] s1, input logic [DL-1:0] s2,
                              input int tag, input int op, input int cnt, input logic full);
    exp_t e;
    e.v = v; e.s1 = v ? s1 : '0; e.s2 = v ? s2 : '0;
    e.tag = v ? RS'(tag) : '0; e.op = v ? 4'(op) : '0; e.dst = v;
    e.cnt = 4'(cnt); e.full = full;
    return e;
  endfunction
  task automatic drive(input in_t v);
    bus.dp_valid_i = v.dv; bus.dp_src1_i = v.s1; bus.dp_rdy1_i = v.r1;
    bus.dp_src2_i = v.s2; bus.dp_rdy2_i = v.r2; bus.dp_rrftag_i = v.tag;
    bus.dp_dstval_i = v.dst; bus.dp_op_i = v.op;
    bus.wb0_valid_i = v.w0v; bus.wb0_rrftag_i = v.w0t; bus.wb0_data_i = v.w0d;
    bus.wb1_valid_i = v.w1v; bus.wb1_rrftag_i = v.w1t; bus.wb1_data_i = v.w1d;
    bus.issue_ready_i = v.rdy; bus.flush_i = v.fl;
  endtask
  task automatic check_out(input string nm, input exp_t e);
    chk({nm, ".valid"}, 64'(bus.issue_valid_o), 64'(e.v));
    chk({nm, ".src1"}, 64'(bus.issue_src1_o), 64'(e.s1));
    chk({nm, ".src2"}, 64'(bus.issue_src2_o), 64'(e.s2));
    chk({nm, ".tag"}, 64'(bus.issue_rrftag_o), 64'(e.tag));
    chk({nm, ".dst"}, 64'(bus.issue_dstval_o), 64'(e.dst));
    chk({nm, ".op"}, 64'(bus.issue_op_o), 64'(e.op));
    chk({nm, ".count"}, 64'(bus.count_o), 64'(e.cnt));
    chk({nm, ".full"}, 64'(bus.full_o), 64'(e.full));
  endtask
  task automatic step(input string nm, input in_t v, input exp_t e);
    drive(v);
    @(negedge clk);
    check_out(nm, e);
    @(posedge clk);
    #1;
  endtask
  // Reference model: a slot array, refilled lowest-free-first.
  logic          m_busy [N];
  logic          m_r1 [N];
  logic          m_r2 [N];
  logic [DL-1:0] m_s1 [N];
  logic [DL-1:0] m_s2 [N];
  logic [RS-1:0] m_tag [N];
  logic          m_dst [N];
  logic [3:0]    m_op [N];
  function automatic logic [DL:0] resolve(input logic r, input logic [DL-1:0] s, input in_t v);
    if (r) return {1'b1, s};
    if (v.w0v && s[RS-1:0] == v.w0t) return {1'b1, v.w0d};
    if (v.w1v && s[RS-1:0] == v.w1t) return {1'b1, v.w1d};
    return {1'b0, s};
  endfunction
  row_t tbl [16];
  initial begin
    in_t v;
    exp_t e;
    drive(idle(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tbl[0] = '{vi: idle(0), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{vi: disp(32'h10, 1, 32'h20, 1, 5, 3, 0), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{vi: idle(1), ve: ex(1, 32'h10, 32'h20, 5, 3, 1, 0)};
    tbl[3] = '{vi: idle(1), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[4] = '{vi: disp(32'h11, 1, 32'h9, 0, 2, 1, 1), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[5] = '{vi: idle(1), ve: ex(0, 0, 0, 0, 0, 1, 0)};
    tbl[6] = '{vi: wb(idle(1), 1, 9, 32'hDEAD), ve: ex(0, 0, 0, 0, 0, 1, 0)};
    tbl[7] = '{vi: idle(1), ve: ex(1, 32'h11, 32'hDEAD, 2, 1, 1, 0)};
    tbl[8] = '{vi: idle(0), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[9] = '{vi: wb(disp(32'h11, 1, 32'h9, 0, 2, 1, 0), 1, 9, 32'hDEAD), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{vi: idle(1), ve: ex(1, 32'h11, 32'hDEAD, 2, 1, 1, 0)};
    tbl[11] = '{vi: idle(0), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{vi: disp(32'h7, 0, 32'h5, 1, 3, 2, 0), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    tbl[13] = '{vi: wb(wb(idle(0), 0, 7, 32'h1), 1, 7, 32'h2), ve: ex(0, 0, 0, 0, 0, 1, 0)};
    tbl[14] = '{vi: idle(1), ve: ex(1, 32'h1, 32'h5, 3, 2, 1, 0)};
    tbl[15] = '{vi: idle(0), ve: ex(0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 16; i++) step($sformatf("dir%0d", i), tbl[i].vi, tbl[i].ve);
    for (int k = 0; k < N; k++)
      step("fill", disp(DL'(32'h100 + k), 1, DL'(32'h200 + k), 1, k, k, 0),
           ex(k > 0, 32'h100, 32'h200, 0, 0, k, 0));
    step("ninth", disp(32'h999, 1, 32'h999, 1, 9, 9, 0), ex(1, 32'h100, 32'h200, 0, 0, 8, 1));
    step("full_hs", idle(1), ex(1, 32'h100, 32'h200, 0, 0, 8, 1));
    step("after_hs", idle(0), ex(1, 32'h101, 32'h201, 1, 1, 7, 0));
    v = idle(0);
    v.fl = 1'b1;
    step("flush_full", v, ex(1, 32'h101, 32'h201, 1, 1, 7, 0));
    step("post_flush", idle(0), ex(0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      step("fill25", (k == 2 || k == 5) ? disp(DL'(32'h300 + k), 1, DL'(32'h400 + k), 1, k, k, 0)
                                        : disp(DL'(20 + k), 0, DL'(32'h400 + k), 1, k, k, 0),
           ex(k > 2, 32'h302, 32'h402, 2, 2, k, 0));
    step("issue2", disp(32'h306, 1, 32'h406, 1, 6, 6, 1), ex(1, 32'h302, 32'h402, 2, 2, 6, 0));
    step("issue5", idle(1), ex(1, 32'h305, 32'h405, 5, 5, 6, 0));
    step("hold6", idle(0), ex(1, 32'h306, 32'h406, 6, 6, 5, 0));
    v = disp(32'h777, 1, 32'h777, 1, 7, 7, 1);
    v.fl = 1'b1;
    step("flush_disp", v, ex(1, 32'h306, 32'h406, 6, 6, 5, 0));
    step("flush_after", idle(1), ex(0, 0, 0, 0, 0, 0, 0));
    step("pre_rst", disp(32'h500, 1, 32'h600, 1, 1, 1, 0), ex(0, 0, 0, 0, 0, 0, 0));
    drive(idle(1));
    rst = 1'b1;
    @(negedge clk);
    check_out("rst_mid", ex(1, 32'h500, 32'h600, 1, 1, 1, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("after_rst", idle(1), ex(0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
    for (int it = 0; it < 400; it++) begin
      int sel, free, cnt;
      logic [DL:0] r;
      v = idle($urandom_range(0, 9) < 6);
      v.dv = $urandom_range(0, 9) < 6;
      v.r1 = 1'($urandom_range(0, 1));
      v.r2 = 1'($urandom_range(0, 1));
      v.s1 = $urandom;
      v.s2 = $urandom;
      if (!v.r1) v.s1[RS-1:0] = RS'($urandom_range(0, 7));
      if (!v.r2) v.s2[RS-1:0] = RS'($urandom_range(0, 7));
      v.tag = RS'($urandom);
      v.dst = 1'($urandom_range(0, 1));
      v.op = 4'($urandom);
      v.w0v = 1'($urandom_range(0, 1));
      v.w0t = RS'($urandom_range(0, 7));
      v.w0d = $urandom;
      v.w1v = 1'($urandom_range(0, 1));
      v.w1t = RS'($urandom_range(0, 7));
      v.w1d = $urandom;
      v.fl = $urandom_range(0, 49) == 0;
      sel = -1;
      free = -1;
      cnt = 0;
      for (int k = 0; k < N; k++) begin
        if (m_busy[k]) cnt++;
        if (sel < 0 && m_busy[k] && m_r1[k] && m_r2[k]) sel = k;
        if (free < 0 && !m_busy[k]) free = k;
      end
      if (sel >= 0) begin
        e = ex(1, m_s1[sel], m_s2[sel], int'(m_tag[sel]), int'(m_op[sel]), cnt, cnt == N);
        e.dst = m_dst[sel];
      end else e = ex(0, 0, 0, 0, 0, cnt, cnt == N);
      step("rand", v, e);
      for (int k = 0; k < N; k++) begin
        if (m_busy[k]) begin
          r = resolve(m_r1[k], m_s1[k], v);
          {m_r1[k], m_s1[k]} = r;
          r = resolve(m_r2[k], m_s2[k], v);
          {m_r2[k], m_s2[k]} = r;
        end
      end
      if (sel >= 0 && v.rdy) m_busy[sel] = 1'b0;
      if (v.dv && cnt < N && free >= 0) begin
        m_busy[free] = 1'b1;
        r = resolve(v.r1, v.s1, v);
        {m_r1[free], m_s1[free]} = r;
        r = resolve(v.r2, v.s2, v);
        {m_r2[free], m_s2[free]} = r;
        m_tag[free] = v.tag;
        m_dst[free] = v.dst;
        m_op[free] = v.op;
      end
      if (v.fl) for (int k = 0; k < N; k++) m_busy[k] = 1'b0;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Out-of-order ALU reservation station, directly downstream of the dispatch-stage source-operand manager.
- Each dispatched instruction arrives with two source operands. Each operand is either ready data or, when not ready, a pending RRF tag in the low `RRF_SEL bits.
- The block buffers up to ENTRY_NUM instructions and captures results from two writeback broadcast ports (wakeup).
- Each cycle it issues the lowest-index fully-ready entry to the ALU through a valid/ready handshake.

Parameters:
- ENTRY_NUM, 8: number of station entries; must be a power of two, minimum 2.
- ENTRY_SEL, 3: log2(ENTRY_NUM).
- OP_W, 4: width of the ALU opcode/control field carried unchanged.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- flush_i  in  1  kill all entries (branch mispredict).
- dp_valid_i  in  1  dispatch request this cycle.
- dp_src1_i  in  `DATA_LEN  operand 1: data if dp_rdy1_i=1, otherwise rrftag in bits [`RRF_SEL-1:0].
- dp_rdy1_i  in  1  operand 1 ready.
- dp_src2_i  in  `DATA_LEN  operand 2, same encoding as operand 1.
- dp_rdy2_i  in  1  operand 2 ready.
- dp_rrftag_i  in  `RRF_SEL  destination rrftag.
- dp_dstval_i  in  1  instruction writes a destination.
- dp_op_i  in  OP_W  ALU opcode.
- wb0_valid_i  in  1  writeback port 0 valid.
- wb0_rrftag_i  in  `RRF_SEL  writeback port 0 tag.
- wb0_data_i  in  `DATA_LEN  writeback port 0 data.
- wb1_valid_i  in  1  writeback port 1 valid.
- wb1_rrftag_i  in  `RRF_SEL  writeback port 1 tag.
- wb1_data_i  in  `DATA_LEN  writeback port 1 data.
- issue_ready_i  in  1  ALU accepts the issued instruction.
- issue_valid_o  out  1  a ready entry is presented.
- issue_src1_o  out  `DATA_LEN  issued operand 1.
- issue_src2_o  out  `DATA_LEN  issued operand 2.
- issue_rrftag_o  out  `RRF_SEL  issued destination tag.
- issue_dstval_o  out  1  issued destination-valid bit.
- issue_op_o  out  OP_W  issued opcode.
- full_o  out  1  all entries busy.
- count_o  out  ENTRY_SEL+1  number of busy entries.

Behaviour:
- Reset (synchronous, reset_i=1 at posedge):
  - All busy bits clear; count_o=0, full_o=0, issue_valid_o=0.
  - Issue data outputs are 0 while issue_valid_o=0.
  - Reset mid-operation discards all entries; no issue is completed in that cycle.
- Per-entry state: busy, src1, rdy1, src2, rdy2, rrftag, dstval, op.
- Allocation:
  - When dp_valid_i=1, full_o=0 and flush_i=0, the request is written into the lowest-index non-busy entry at the next posedge.
  - Dispatch while full_o=1 is ignored; the dispatcher must stall on full_o.
  - full_o reflects registered busy bits only; an entry freed by issue in the same cycle is not reused until the following cycle.
- Wakeup (every cycle):
  - For each busy entry with rdyN=0 and srcN[`RRF_SEL-1:0]==wbK_rrftag_i with wbK_valid_i=1: at the posedge, srcN<=wbK_data_i and rdyN<=1.
  - If both ports match the same operand, port 0 wins.
  - The same tag comparison is applied to the incoming dispatch operands, so a result broadcast in the dispatch cycle is captured as ready data.
- Select/issue:
  - Ready entry = busy & rdy1 & rdy2 (registered state only).
  - issue_valid_o=1 if any entry is ready.
  - Outputs are combinational from the lowest-index ready entry.
  - Latency: an entry made ready by wakeup or dispatch at posedge N is issuable from cycle N onward, i.e. one cycle after the broadcast/dispatch cycle. There is no same-cycle wakeup-to-issue.
  - Handshake: when issue_valid_o & issue_ready_i are both 1 at a posedge, the selected entry's busy bit clears.
  - With issue_ready_i=0 the selection holds stable unless a lower-index entry becomes ready. The outputs then switch to that lower-index entry; this is legal because the ALU has not accepted the instruction.
- Counter:
  - count_o += dispatch accepted, -= issue handshake; both in the same cycle leave it unchanged.
  - full_o = (count_o==ENTRY_NUM).
- Flush:
  - flush_i=1 clears all busy bits at the posedge; count_o=0 next cycle.
  - Any same-cycle dispatch is dropped.
  - An issue handshake in the flush cycle is still considered accepted by the ALU; the station only clears state.

Test Plan:
- Reset, then dispatch op=3, src1=0x10 rdy, src2=0x20 rdy, rrftag=5. Expect issue_valid_o=1 next cycle with src1=0x10, src2=0x20, rrftag=5, op=3. With issue_ready_i=1, count_o returns to 0.
- Dispatch with src2 not ready (tag 9); issue_valid_o stays 0. Broadcast wb1 tag=9 data=0xDEAD. The next cycle issues with src2=0xDEAD. Same broadcast in the dispatch cycle gives an identical result.
- Dispatch 8 ready instructions with issue_ready_i=0. Expect full_o=1, count_o=8; a ninth dispatch is ignored. One handshake gives count_o=7, full_o=0.
- Entries 2 and 5 ready, issue_ready_i=1. Entry 2 issues first, entry 5 in the next cycle. Simultaneous dispatch plus issue keeps count_o unchanged.
- Fill 4 entries, then assert flush_i with dp_valid_i=1. Next cycle: count_o=0, issue_valid_o=0, dispatched instruction absent.
- wb0 and wb1 both tag 7 with data 0x1 and 0x2 to an entry waiting on tag 7. The captured operand is 0x1.
